// File: rtl/reg8_collect.sv
// Serial-to-parallel collector: packs DEPTH words of N bits into one group, word 0 in the LSBs.
// The fill buffer and the registered output slot form a two-stage buffer with valid/ready on both sides.
module reg8_collect #(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [N*DEPTH-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         fill_cnt
);

    localparam logic [3:0] CntMax  = 4'(DEPTH);
    localparam logic [3:0] CntLast = 4'(DEPTH - 1);

    typedef enum logic {
        StFill,
        StFull
    } state_t;

    state_t               r_state;
    logic [3:0]           r_cnt;
    logic [N*DEPTH-1:0]   r_buf;
    logic [N*DEPTH-1:0]   r_out_data;
    logic                 r_out_valid;

    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_slot_free;
    logic [N*DEPTH-1:0]   w_buf_next;

    assign w_in_ready  = (r_state == StFill) && !flush;
    assign w_accept    = in_valid && w_in_ready;
    assign w_last      = (r_cnt == CntLast);
    assign w_slot_free = !r_out_valid || out_ready;

    // Fill buffer with the incoming word merged at its slot; lets the last word
    // go straight to the output slot on the same edge it is accepted.
    always_comb begin
        w_buf_next = r_buf;
        for (int k = 0; k < DEPTH; k++) begin
            if (r_cnt == 4'(k)) begin
                w_buf_next[N*k +: N] = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StFill;
            r_cnt       <= 4'd0;
            r_buf       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // Drain by default; a group loading on this edge overrides below.
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                StFill: begin
                    if (flush) begin
                        r_cnt <= 4'd0;
                    end else if (w_accept) begin
                        r_buf <= w_buf_next;
                        if (w_last) begin
                            if (w_slot_free) begin
                                r_out_data  <= w_buf_next;
                                r_out_valid <= 1'b1;
                                r_cnt       <= 4'd0;
                            end else begin
                                r_state <= StFull;
                                r_cnt   <= CntMax;
                            end
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                StFull: begin
                    if (flush) begin
                        r_state <= StFill;
                        r_cnt   <= 4'd0;
                    end else if (out_ready) begin
                        r_out_data  <= r_buf;
                        r_out_valid <= 1'b1;
                        r_cnt       <= 4'd0;
                        r_state     <= StFill;
                    end
                end
                default: begin
                    r_state <= StFill;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign fill_cnt  = r_cnt;

endmodule

// File: doc/reg8_collect.md
REG8_COLLECT -- requirements
Module: reg8_collect

Interface
REQ-001 SHALL have parameter N, default 8: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8: words per assembled group; only 8 is supported.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_data  input  N: serial input word.
REQ-006 SHALL have port in_valid  input  1: in_data is valid this cycle.
REQ-007 SHALL have port in_ready  output  1: block can accept a word this cycle.
REQ-008 SHALL have port flush  input  1: synchronous discard of the partial group.
REQ-009 SHALL have port out_data  output  N*DEPTH: assembled group.
REQ-010 SHALL have port out_valid  output  1: out_data holds an unconsumed group.
REQ-011 SHALL have port out_ready  input  1: downstream takes the group this cycle.
REQ-012 SHALL have port fill_cnt  output  4: words currently in the fill buffer, range 0..DEPTH.

Function
REQ-013 SHALL accept a word on a rising edge only when in_valid=1 and in_ready=1 (input handshake).
REQ-014 SHALL store the k-th accepted word of a group (k=0..DEPTH-1) at fill buffer bits [N*k +: N], so word 0 lands in the LSBs.
REQ-015 SHALL contain an internal fill buffer and an independent registered output slot (out_data/out_valid), forming a two-stage buffer.
REQ-016 SHALL implement FSM state FILL: fill_cnt 0..DEPTH-1, in_ready=1 unless flush=1.
REQ-017 SHALL implement FSM state FULL: fill_cnt=DEPTH, group complete but output slot occupied, in_ready=0.
REQ-018 SHALL free the output slot in a cycle when out_valid=0, or when out_valid=1 and out_ready=1.
REQ-019 SHALL, when the DEPTH-th word is accepted and the slot is free, load the complete group (including that word) into out_data at that same edge, set out_valid=1, set fill_cnt=0, and remain in FILL; latency is therefore 1 edge from the last word accepted to out_valid.
REQ-020 SHALL, when the DEPTH-th word is accepted and the slot is not free, go to FULL with fill_cnt=DEPTH.
REQ-021 SHALL, in FULL, transfer the buffered group to out_data at the edge where out_valid=1 and out_ready=1, keep out_valid=1, set fill_cnt=0, and return to FILL; no bubble.
REQ-022 SHALL clear out_valid after an edge with out_valid=1 and out_ready=1 unless a new group loads at that same edge.
REQ-023 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, when flush=1 in FILL, set fill_cnt=0 at the next edge; in_ready SHALL be 0 in that cycle, so no word is accepted; the output slot is unaffected.
REQ-025 SHALL, when flush=1 in FULL, discard the buffered group, set fill_cnt=0, and go to FILL; if out_ready=1 in the same cycle, the slot drains normally and no transfer occurs.
REQ-026 SHALL drive in_ready combinationally: in_ready = (state==FILL) and not flush.
REQ-027 SHALL leave fill-buffer words above fill_cnt undefined to the user; out_data SHALL expose only complete groups.
REQ-028 SHALL ignore in_data whenever in_valid=0 or in_ready=0.

Reset
REQ-029 SHALL, while rst_n=0, force state=FILL, fill_cnt=0, out_valid=0, out_data=0, and fill buffer=0, independent of clk.
REQ-030 SHALL drive in_ready=1 in the reset state with flush=0; an assertion of rst_n mid-group discards the partial group and any held output group.
REQ-031 SHALL accept the first word at the first rising edge after rst_n rises, provided in_valid=1.

Verification
REQ-032 Bench SHALL cover: in_data 1..8 on consecutive cycles, out_ready=1 -> out_valid=1 after the 8th edge, out_data=64'h0807060504030201, fill_cnt=0.
REQ-033 Bench SHALL cover: 8 words 1..8 with out_ready=0, then words 9..16 -> fill_cnt reaches 8, in_ready=0, out_data still 64'h0807060504030201; set out_ready=1 -> next edge out_data=64'h100F0E0D0C0B0A09, out_valid=1, in_ready=1.
REQ-034 Bench SHALL cover: 3 words accepted, then flush=1 for 1 cycle with in_valid=1, in_data=0xAA -> fill_cnt=0, 0xAA not stored, next group 1..8 gives 64'h0807060504030201.
REQ-035 Bench SHALL cover: in_valid toggled every other cycle over words 1..8 -> fill_cnt increments only on handshake edges, out_data=64'h0807060504030201.
REQ-036 Bench SHALL cover: rst_n=0 after 5 words with out_valid=1 held -> immediately out_valid=0, out_data=0, fill_cnt=0; after release, words 17..24 give 64'h1817161514131211.
